push_button_conditioner: RTL and testbench
==========================================

// Module: push_button_conditioner
// PURPOSE
//   Conditions the 5 raw board push buttons (u,d,l,r,m) before they reach the
//   Service_1..4 blocks: 2-FF synchronizer, per-button debounce, one-cycle press
//   pulse, and optional auto-repeat pulses while a button is held.
//   Sits between the top-level push[4:0] pins and the push_* service inputs.
// PARAMETERS
//   N_BTN          5      number of buttons; bit order u=0,d=1,l=2,r=3,m=4
//   DEBOUNCE_CYC   16     consecutive equal synced samples required to change level
//   REPEAT_DELAY   32     held cycles after press before the first repeat pulse
//   REPEAT_PERIOD  8      cycles between subsequent repeat pulses
//   REPEAT_MASK    5'b00011  buttons with auto-repeat enabled (u,d by default)
// PORTS
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   push_raw     in   N_BTN  raw, asynchronous button inputs
//   push_level   out  N_BTN  debounced button level
//   push_pulse   out  N_BTN  1-cycle pulse on debounced press, plus repeat pulses
//   push_press   out  N_BTN  1-cycle pulse on debounced press only (no repeat)
//   any_press    out  1      OR of push_press
// BEHAVIOUR
//   - Reset: sync flops, counters, FSMs cleared; all outputs 0 while reset high.
//   - Sync: 2 flops per bit; raw edge reaches the debouncer after 2 clk.
//   - Per-channel FSM (independent, no inter-button priority):
//       RELEASED : level=0; synced=1 -> ARMING, cnt=1
//       ARMING   : synced=1 -> cnt++; cnt==DEBOUNCE_CYC -> PRESSED;
//                  synced=0 -> RELEASED, cnt=0 (bounce restarts count)
//       PRESSED  : level=1; synced=0 -> DISARM, cnt=1; else hold counter runs
//       DISARM   : synced=0 -> cnt++; cnt==DEBOUNCE_CYC -> RELEASED;
//                  synced=1 -> PRESSED, cnt=0 (hold counter keeps running)
//   - Latency: raw stable high from cycle 0 -> level/press/pulse high in cycle
//     2+DEBOUNCE_CYC; press/pulse high exactly 1 cycle. Release symmetric, no pulse.
//   - Repeat (REPEAT_MASK bit=1 only): hold counter clears on entry to PRESSED;
//     pulse when hold==REPEAT_DELAY, then every REPEAT_PERIOD cycles while in
//     PRESSED/DISARM. Counter saturates, never wraps into a spurious pulse.
//   - Unmasked buttons: push_pulse == push_press.
//   - Counter widths $clog2(max(param)+1); no overflow for any legal param.
//   - Simultaneous presses of several buttons: each pulses in its own cycle
//     (same cycle if edges coincide); any_press = OR.
//   - Reset mid-press: outputs drop immediately; a button still held after
//     reset release must re-debounce and then produces a new press pulse.
//   - Params: DEBOUNCE_CYC>=1, REPEAT_PERIOD>=1; violations are $error at elab.
// STRUCTURE
//   - Shared package btn_pkg: BTN_U/D/L/R/M index constants, N_BTN, FSM state
//     encoding (RELEASED, ARMING, PRESSED, DISARM), default timing constants.
//   - Sub-module btn_debounce_channel: sync + FSM + hold/repeat counter for one
//     bit; top generates N_BTN instances with REPEAT_MASK[i] as its enable.
//   - All outputs registered; no combinational path from push_raw to outputs.
// TESTING  (bench params DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//   - Clean press: raw[4] 0->1 at cycle 0, held 20 -> level[4]=1 at cycle 6;
//     press[4], pulse[4] high only at cycle 6; no repeat (mask bit 0).
//   - Bounce: raw[2] pattern 1,1,0,1,1,1,1 -> exactly one press, issued 4 stable
//     samples after the last 0; release bounce 0,1,0,0,0,0 -> no pulse.
//   - Auto-repeat: raw[0] held 30 cycles -> press at 6, pulse at 6,14,17,20,23,26,
//     (29,...) while held; push_press once; released -> pulses stop.
//   - Simultaneous: raw[0] and raw[3] rise same cycle -> press[0]&press[3] both at
//     cycle 6, any_press=1 one cycle only.
//   - Reset mid-hold: assert reset at cycle 10 of a held raw[1] for 3 cycles ->
//     all outputs 0 immediately; after release, new press 6 cycles later.
//   - Short glitch: raw[3] high 3 cycles -> no level change, no pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: button indices, default
// timing constants, per-channel FSM encoding and a counter-width helper.
// No ports; imported by btn_debounce_channel and referenced by the top.
package btn_pkg;

    localparam int N_BTN = 5;

    // Bit positions of the board buttons in push_raw/push_* vectors.
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_M = 4;

    localparam int                 DEF_DEBOUNCE_CYC  = 16;
    localparam int                 DEF_REPEAT_DELAY  = 32;
    localparam int                 DEF_REPEAT_PERIOD = 8;
    localparam logic [N_BTN-1:0]   DEF_REPEAT_MASK   = 5'b00011;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        ARMING   = 2'd1,
        PRESSED  = 2'd2,
        DISARM   = 2'd3
    } btn_state_e;

    // Bits needed to hold 0..max_val; never zero so a zero-valued parameter
    // still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-FF synchronizer, debounce FSM, hold counter with auto-repeat.
// Ports: clk, reset (async, active high), raw_i (async pin); level_o, pulse_o,
// press_o (all registered) and press_next_o (D input of press_o, for OR-ing).
module btn_debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o,
    output logic press_o,
    output logic press_next_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYC);
    localparam int HW = cnt_width(REPEAT_DELAY);
    localparam int PW = cnt_width(REPEAT_PERIOD);

    localparam logic [DW-1:0] DEB_C = DW'(DEBOUNCE_CYC);
    localparam logic [HW-1:0] RD_C  = HW'(REPEAT_DELAY);
    localparam logic [PW-1:0] RP_C  = PW'(REPEAT_PERIOD);

    logic          sync1_q, sync2_q;
    btn_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] per_q, per_d, per_inc;
    logic          press_d, rep_fire, level_d, pulse_d;
    logic          level_q, pulse_q, press_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            hold_q  <= '0;
            per_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            per_q   <= per_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        per_d    = per_q;
        press_d  = 1'b0;
        rep_fire = 1'b0;
        // cnt_q is 0 in RELEASED/PRESSED, so +1 also gives the first count.
        cnt_inc  = cnt_q + DW'(1);
        per_inc  = per_q + PW'(1);

        case (state_q)
            RELEASED, ARMING: begin
                if (sync2_q) begin
                    if (cnt_inc == DEB_C) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        hold_d  = '0;
                        per_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        state_d = ARMING;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            end
            PRESSED, DISARM: begin
                if (!sync2_q && (cnt_inc == DEB_C)) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    if (!sync2_q) begin
                        state_d = DISARM;
                        cnt_d   = cnt_inc;
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                    // Hold counter saturates at the delay; afterwards a
                    // separate modulo-period counter paces repeat pulses.
                    if (REPEAT_EN) begin
                        if (hold_q != RD_C) begin
                            hold_d = hold_q + HW'(1);
                            if (hold_d == RD_C) begin
                                rep_fire = 1'b1;
                                per_d    = '0;
                            end
                        end else if (per_inc == RP_C) begin
                            rep_fire = 1'b1;
                            per_d    = '0;
                        end else begin
                            per_d = per_inc;
                        end
                    end
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == DISARM);
        pulse_d = press_d | rep_fire;
    end

    assign level_o      = level_q;
    assign pulse_o      = pulse_q;
    assign press_o      = press_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/push_button_conditioner.sv
// Conditions N_BTN raw push buttons: sync, debounce, press pulse, auto-repeat.
// Ports: clk, reset (async, active high), push_raw in; push_level, push_pulse,
// push_press, any_press out, all registered (no comb path from push_raw).
module push_button_conditioner #(
    parameter int               N_BTN         = btn_pkg::N_BTN,
    parameter int               DEBOUNCE_CYC  = btn_pkg::DEF_DEBOUNCE_CYC,
    parameter int               REPEAT_DELAY  = btn_pkg::DEF_REPEAT_DELAY,
    parameter int               REPEAT_PERIOD = btn_pkg::DEF_REPEAT_PERIOD,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(btn_pkg::DEF_REPEAT_MASK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] push_raw,
    output logic [N_BTN-1:0] push_level,
    output logic [N_BTN-1:0] push_pulse,
    output logic [N_BTN-1:0] push_press,
    output logic             any_press
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("push_button_conditioner: DEBOUNCE_CYC must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("push_button_conditioner: REPEAT_PERIOD must be >= 1");
    end

    logic [N_BTN-1:0] press_next;
    logic             any_press_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_channel #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .raw_i        (push_raw[i]),
            .level_o      (push_level[i]),
            .pulse_o      (push_pulse[i]),
            .press_o      (push_press[i]),
            .press_next_o (press_next[i])
        );
    end

    // Registered from the channels' next-press terms so it lines up with push_press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_push_button_conditioner.sv
module tb_push_button_conditioner;

    localparam int              NB   = 5;
    localparam int              DEB  = 4;
    localparam int              RD   = 8;
    localparam int              RP   = 3;
    localparam logic [NB-1:0]   MASK = 5'b00011;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] push_raw;
    logic [NB-1:0] push_level, push_pulse, push_press;
    logic          any_press;

    always #5 clk = ~clk;

    push_button_conditioner #(
        .N_BTN(NB), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .push_raw(push_raw),
        .push_level(push_level), .push_pulse(push_pulse),
        .push_press(push_press), .any_press(any_press)
    );

    // Reference model: delay line for the synchronizer, then "level flips
    // after DEB consecutive samples disagreeing with it", repeat timing from
    // cycles elapsed since the press.
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_press, m_pulse;
    logic          m_any;
    int            m_run [NB];
    int            m_hold[NB];

    int n_chk = 0, n_fail = 0, cyc_n = 0, t0 = 0;
    int cnt_press[NB], cnt_pulse[NB], first_press[NB];
    int cnt_any;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_pulse = '0; m_any = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0; m_hold[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic smp;
        m_press = '0;
        m_pulse = '0;
        for (int i = 0; i < NB; i++) begin
            smp     = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = push_raw[i];
            m_run[i] = (smp != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DEB) begin
                m_lvl[i] = ~m_lvl[i];
                m_run[i] = 0;
                if (m_lvl[i]) begin
                    m_press[i] = 1'b1;
                    m_pulse[i] = 1'b1;
                    m_hold[i]  = 0;
                end
            end else if (m_lvl[i] && MASK[i]) begin
                m_hold[i]++;
                if (m_hold[i] >= RD && ((m_hold[i] - RD) % RP) == 0)
                    m_pulse[i] = 1'b1;
            end
        end
        m_any = |m_press;
    endtask

    task automatic compare_outputs();
        check_val("level", 32'(push_level), 32'(m_lvl));
        check_val("pulse", 32'(push_pulse), 32'(m_pulse));
        check_val("press", 32'(push_press), 32'(m_press));
        check_val("any",   32'(any_press),  32'(m_any));
    endtask

    task automatic step();
        @(posedge clk);
        cyc_n++;
        if (reset) model_clear();
        else       model_edge();
        #1;
        compare_outputs();
        for (int i = 0; i < NB; i++) begin
            if (push_press[i]) begin
                cnt_press[i]++;
                if (first_press[i] < 0) first_press[i] = cyc_n - t0;
            end
            if (push_pulse[i]) cnt_pulse[i]++;
        end
        if (any_press) cnt_any++;
    endtask

    task automatic start_scn();
        for (int i = 0; i < NB; i++) begin
            cnt_press[i] = 0; cnt_pulse[i] = 0; first_press[i] = -1;
        end
        cnt_any = 0;
        t0 = cyc_n;
    endtask

    task automatic hold(input logic [NB-1:0] r, input int n);
        push_raw = r;
        repeat (n) step();
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_clear();
        #1;
        compare_outputs();
    endtask

    int bnc_press[7] = '{1, 1, 0, 1, 1, 1, 1};
    int bnc_rel[6]   = '{0, 1, 0, 0, 0, 0};

    initial begin
        reset    = 1'b1;
        push_raw = '0;
        model_clear();
        start_scn();
        repeat (3) step();
        reset = 1'b0;
        hold('0, 4);

        // Clean press of m
        start_scn();
        hold(5'b10000, 20);
        hold('0, 10);
        check_val("clean_press_cnt", 32'(cnt_press[4]), 32'd1);
        check_val("clean_press_cyc", 32'(first_press[4]), 32'd6);
        check_val("clean_pulse_cnt", 32'(cnt_pulse[4]), 32'd1);

        // Bounce on press and on release of l
        start_scn();
        for (int k = 0; k < 7; k++) hold((bnc_press[k] != 0) ? 5'b00100 : 5'b00000, 1);
        hold(5'b00100, 8);
        for (int k = 0; k < 6; k++) hold((bnc_rel[k] != 0) ? 5'b00100 : 5'b00000, 1);
        hold('0, 10);
        check_val("bounce_press_cnt", 32'(cnt_press[2]), 32'd1);
        check_val("bounce_press_cyc", 32'(first_press[2]), 32'd9);
        check_val("bounce_pulse_cnt", 32'(cnt_pulse[2]), 32'd1);

        // Auto-repeat on u: pulses 6,14,17,...,35
        start_scn();
        hold(5'b00001, 30);
        hold('0, 15);
        check_val("repeat_press_cnt", 32'(cnt_press[0]), 32'd1);
        check_val("repeat_press_cyc", 32'(first_press[0]), 32'd6);
        check_val("repeat_pulse_cnt", 32'(cnt_pulse[0]), 32'd9);

        // Simultaneous u and r
        start_scn();
        hold(5'b01001, 10);
        hold('0, 12);
        check_val("simul_press0_cyc", 32'(first_press[0]), 32'd6);
        check_val("simul_press3_cyc", 32'(first_press[3]), 32'd6);
        check_val("simul_any_cnt", 32'(cnt_any), 32'd1);

        // Reset in the middle of holding d
        start_scn();
        hold(5'b00010, 10);
        assert_reset();
        repeat (3) step();
        start_scn();
        reset = 1'b0;
        hold(5'b00010, 12);
        hold('0, 10);
        check_val("rst_repress_cnt", 32'(cnt_press[1]), 32'd1);
        check_val("rst_repress_cyc", 32'(first_press[1]), 32'd6);

        // Short glitch on r
        start_scn();
        hold(5'b01000, 3);
        hold('0, 10);
        check_val("glitch_press_cnt", 32'(cnt_press[3]), 32'd0);
        check_val("glitch_pulse_cnt", 32'(cnt_pulse[3]), 32'd0);

        // Random traffic: fast toggling, then long holds, occasional reset
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 300; c++) begin
                for (int i = 0; i < NB; i++)
                    if ($urandom_range(0, (ph == 0) ? 3 : 19) == 0) push_raw[i] = ~push_raw[i];
                if ($urandom_range(0, 149) == 0) begin
                    assert_reset();
                    step();
                    step();
                    reset = 1'b0;
                end
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
